aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Iterative controller sitting directly upstream of the modified-AES round datapath (`ROUND_ITERATION`). Accepts a 128-bit plaintext and a 128-bit cipher key over a valid/ready handshake and applies initial whitening (plaintext XOR key). It then drives the round datapath once per round with the round index, current state and current key, feeding each round's `OUT_DATA`/`OUT_KEY` back. After the last round it presents the ciphertext on a valid/ready output.

## Interface
- `NUM_ROUNDS`, 10: number of round iterations, legal range 1..15.
- `ROUND_LAT`, 1: cycles from driving the round inputs to sampling the round outputs, legal range 1..8; 1 means the round stage is combinational.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `IN_VALID` input 1: plaintext/key offered.
- `IN_READY` output 1: sequencer can accept.
- `PLAIN_TEXT` input 128: plaintext.
- `CIPHER_KEY` input 128: cipher key.
- `RND_NUM` output 4: round index to the datapath's `ROUND_KEY`.
- `RND_DATA` output 128: state to the datapath's `IN_DATA`.
- `RND_KEY` output 128: key to the datapath's `IN_KEY`.
- `RND_OUT_DATA` input 128: datapath `OUT_DATA`.
- `RND_OUT_KEY` input 128: datapath `OUT_KEY`.
- `OUT_VALID` output 1: ciphertext valid.
- `OUT_READY` input 1: consumer accepts.
- `CIPHER_TEXT` output 128: ciphertext (equals the state register).
- `BUSY` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- Registers: `state_q`[127:0], `key_q`[127:0], `rnd_q`[3:0], `lat_q`[2:0].
- IDLE: `IN_READY`=1. When `IN_VALID` is high, load `state_q`=PLAIN_TEXT^CIPHER_KEY, `key_q`=CIPHER_KEY, `rnd_q`=1 and `lat_q`=0, then go to RUN.
- RUN: `RND_NUM`=`rnd_q`, `RND_DATA`=`state_q`, `RND_KEY`=`key_q`. These outputs are held stable for the whole round.
- RUN, `lat_q`<ROUND_LAT-1: increment `lat_q`.
- RUN, `lat_q`==ROUND_LAT-1: capture `state_q`←RND_OUT_DATA and `key_q`←RND_OUT_KEY, and clear `lat_q`.
  - If `rnd_q`==NUM_ROUNDS, go to DONE.
  - Otherwise increment `rnd_q`.
- DONE: `OUT_VALID`=1 and `CIPHER_TEXT`=`state_q`, both held until `OUT_READY` is high; then go to IDLE. `OUT_READY` with `OUT_VALID` low is ignored.
- `IN_READY` is 0 in RUN and DONE. There is no new accept in the same cycle as an output handshake; the next accept is possible one cycle after.
- Every round uses the same datapath; no special final round. The round index wraps nowhere because NUM_ROUNDS ≤ 15.
- Input changes while not accepting (RUN/DONE) have no effect.
- Reset mid-operation: the current block is discarded with no output produced; the FSM returns to IDLE.

## Timing
- Reset values:
  - `IN_READY`=1, `OUT_VALID`=0, `BUSY`=0.
  - `RND_NUM`=0, `RND_DATA`=0, `RND_KEY`=0, `CIPHER_TEXT`=0.
  - All internal registers 0.
- Outside RUN, `RND_NUM`/`RND_DATA`/`RND_KEY` are driven 0.
- Latency: with the accept at edge E0, `OUT_VALID` rises after edge E0+NUM_ROUNDS*ROUND_LAT. Defaults give 10 cycles.
- Throughput: one block per NUM_ROUNDS*ROUND_LAT+2 cycles when `OUT_READY` is held high.
- `OUT_VALID` and `CIPHER_TEXT` are registered; there is no combinational path from `OUT_READY` to them.
- `IN_READY` is decoded from state only; there is no combinational path from `IN_VALID`.

## Structure
- Shared package `aes_pkg`:
  - Block and key width constant (128).
  - Round-index width (4).
  - Default NUM_ROUNDS (10).
  - FSM state enum {IDLE, RUN, DONE}.
- Single module with no sub-module. The round datapath is instantiated beside it at the top level, not inside it.

## Test plan
All scenarios use a bench stub datapath: OUT_DATA = IN_DATA + ROUND_KEY (mod 2^128) and OUT_KEY = IN_KEY ^ {124'b0, ROUND_KEY}, with latency ROUND_LAT.
- Defaults, PLAIN_TEXT=0, CIPHER_KEY=0:
  - `CIPHER_TEXT`=0x37 (sum 1..10).
  - `OUT_VALID` rises exactly 10 cycles after the accept edge.
  - `RND_NUM` steps 1..10, one step per cycle.
- ROUND_LAT=3, PLAIN_TEXT=0xFF, CIPHER_KEY=0x0F:
  - Whitened state is 0xF0; `CIPHER_TEXT`=0x127.
  - `OUT_VALID` rises 30 cycles after the accept.
  - Each `RND_NUM` value is held 3 cycles.
- `OUT_READY` held low for 5 cycles in DONE: `OUT_VALID` and `CIPHER_TEXT` stay stable, `IN_READY` stays 0, and a new `IN_VALID` pulse is ignored.
- Back-to-back blocks with `OUT_READY`=1 and `IN_VALID`=1 constant: accepts occur every 12 cycles (defaults), and both results are correct and in order.
- `rst_n` asserted low in RUN at round 4:
  - All outputs return to reset values asynchronously and no `OUT_VALID` occurs.
  - A fresh block after release completes normally.
- NUM_ROUNDS=1: `OUT_VALID` rises 1 cycle after the accept, with `CIPHER_TEXT`=PLAIN_TEXT^CIPHER_KEY+1.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and FSM state type for the AES round sequencer
//
// Purpose : widths, default round count and the sequencer state enum shared by
//           the sequencer and its surrounding top level.
// Contents: BLOCK_W        - block and key width in bits
//           RND_W          - round-index width in bits
//           DEF_NUM_ROUNDS - default number of round iterations
//           seq_state_e    - IDLE / RUN / DONE

package aes_pkg;

    localparam int BLOCK_W        = 128;
    localparam int RND_W          = 4;
    localparam int DEF_NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative controller driving an external AES round datapath
//
// Purpose : accepts plaintext/key, whitens (plaintext ^ key), then walks the
//           external round datapath NUM_ROUNDS times, feeding each round's
//           outputs back, and finally presents the ciphertext.
// Params  : NUM_ROUNDS (1..15) round iterations
//           ROUND_LAT  (1..8)  cycles from driving round inputs to sampling outputs
// Ports   : clk, rst_n                    clock, async active-low reset
//           IN_VALID/IN_READY             input handshake
//           PLAIN_TEXT, CIPHER_KEY        128-bit block and key
//           RND_NUM/RND_DATA/RND_KEY      round datapath inputs (0 outside RUN)
//           RND_OUT_DATA/RND_OUT_KEY      round datapath outputs
//           OUT_VALID/OUT_READY           output handshake
//           CIPHER_TEXT                   state register (ciphertext in DONE)
//           BUSY                          high outside IDLE

module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int ROUND_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [BLOCK_W-1:0] PLAIN_TEXT,
    input  logic [BLOCK_W-1:0] CIPHER_KEY,
    output logic [RND_W-1:0]   RND_NUM,
    output logic [BLOCK_W-1:0] RND_DATA,
    output logic [BLOCK_W-1:0] RND_KEY,
    input  logic [BLOCK_W-1:0] RND_OUT_DATA,
    input  logic [BLOCK_W-1:0] RND_OUT_KEY,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [BLOCK_W-1:0] CIPHER_TEXT,
    output logic               BUSY
);

    localparam logic [2:0]       LAT_LAST = 3'(ROUND_LAT - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS);

    seq_state_e         fsm_q, fsm_d;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [2:0]         lat_q, lat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            lat_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        lat_d   = lat_q;

        unique case (fsm_q)
            IDLE: begin
                if (IN_VALID) begin
                    state_d = PLAIN_TEXT ^ CIPHER_KEY;
                    key_d   = CIPHER_KEY;
                    rnd_d   = RND_W'(1);
                    lat_d   = '0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                // Datapath inputs stay constant for the whole round, so the
                // outputs are valid once ROUND_LAT-1 extra cycles have elapsed.
                if (lat_q != LAT_LAST) begin
                    lat_d = lat_q + 3'd1;
                end else begin
                    state_d = RND_OUT_DATA;
                    key_d   = RND_OUT_KEY;
                    lat_d   = '0;
                    if (rnd_q == RND_LAST) begin
                        fsm_d = DONE;
                    end else begin
                        rnd_d = rnd_q + RND_W'(1);
                    end
                end
            end
            DONE: begin
                // Return through IDLE so the next accept is one cycle after
                // the output handshake, never in the same cycle.
                if (OUT_READY) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // All handshake outputs are decoded from registered state only.
    assign IN_READY    = (fsm_q == IDLE);
    assign BUSY        = (fsm_q != IDLE);
    assign OUT_VALID   = (fsm_q == DONE);
    assign CIPHER_TEXT = state_q;

    assign RND_NUM  = (fsm_q == RUN) ? rnd_q   : '0;
    assign RND_DATA = (fsm_q == RUN) ? state_q : '0;
    assign RND_KEY  = (fsm_q == RUN) ? key_q   : '0;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer (three configurations)

module tb_aes_round_sequencer;

    logic clk;
    int   cyc;
    int   n_tests;
    int   n_fail;

    logic         rst_n     [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] pt        [3];
    logic [127:0] ck        [3];
    logic [3:0]   rnd_num   [3];
    logic [127:0] rnd_data  [3];
    logic [127:0] rnd_key   [3];
    logic [127:0] rod       [3];
    logic [127:0] rok       [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] ct        [3];
    logic         busy      [3];

    // reference model state: 0 idle, 1 run, 2 done
    int           m_mode [3];
    int           m_acc  [3];
    logic [127:0] m_pt   [3];
    logic [127:0] m_k    [3];
    logic [127:0] m_last [3];

    function automatic int nr_of(input int g);
        return (g == 2) ? 1 : 10;
    endfunction

    function automatic int rl_of(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    // state after n rounds of the stub datapath (data += round index)
    function automatic logic [127:0] exp_data(input logic [127:0] p, input logic [127:0] k, input int n);
        logic [127:0] s;
        s = p ^ k;
        for (int r = 1; r <= n; r++) s = s + 128'(r);
        return s;
    endfunction

    // key after n rounds of the stub datapath (key ^= round index)
    function automatic logic [127:0] exp_key(input logic [127:0] k, input int n);
        logic [127:0] x;
        x = k;
        for (int r = 1; r <= n; r++) x = x ^ 128'(r);
        return x;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NR = (g == 2) ? 1 : 10;
        localparam int RL = (g == 1) ? 3 : 1;

        aes_round_sequencer #(.NUM_ROUNDS(NR), .ROUND_LAT(RL)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .IN_VALID     (in_valid[g]),
            .IN_READY     (in_ready[g]),
            .PLAIN_TEXT   (pt[g]),
            .CIPHER_KEY   (ck[g]),
            .RND_NUM      (rnd_num[g]),
            .RND_DATA     (rnd_data[g]),
            .RND_KEY      (rnd_key[g]),
            .RND_OUT_DATA (rod[g]),
            .RND_OUT_KEY  (rok[g]),
            .OUT_VALID    (out_valid[g]),
            .OUT_READY    (out_ready[g]),
            .CIPHER_TEXT  (ct[g]),
            .BUSY         (busy[g])
        );

        // stub round datapath with RL-1 register stages
        logic [127:0] f_data, f_key;
        assign f_data = rnd_data[g] + {124'b0, rnd_num[g]};
        assign f_key  = rnd_key[g] ^ {124'b0, rnd_num[g]};

        if (RL == 1) begin : g_comb
            assign rod[g] = f_data;
            assign rok[g] = f_key;
        end else begin : g_pipe
            logic [127:0] pd [RL-1];
            logic [127:0] pk [RL-1];
            always @(posedge clk) begin
                pd[0] <= f_data;
                pk[0] <= f_key;
                for (int i = 1; i < RL - 1; i++) begin
                    pd[i] <= pd[i-1];
                    pk[i] <= pk[i-1];
                end
            end
            assign rod[g] = pd[RL-2];
            assign rok[g] = pk[RL-2];
        end

        // reference model: phase tracked by elapsed-cycle arithmetic
        always @(posedge clk or negedge rst_n[g]) begin
            if (!rst_n[g]) begin
                m_mode[g] <= 0;
                m_acc[g]  <= 0;
                m_pt[g]   <= '0;
                m_k[g]    <= '0;
                m_last[g] <= '0;
            end else begin
                case (m_mode[g])
                    0: if (in_valid[g]) begin
                        m_mode[g] <= 1;
                        m_acc[g]  <= cyc;
                        m_pt[g]   <= pt[g];
                        m_k[g]    <= ck[g];
                    end
                    1: if (cyc - m_acc[g] == NR * RL) begin
                        m_mode[g] <= 2;
                        m_last[g] <= exp_data(m_pt[g], m_k[g], NR);
                    end
                    default: if (out_ready[g]) m_mode[g] <= 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle compare of every instance against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                logic         e_ir, e_busy, e_ov;
                logic [3:0]   e_rn;
                logic [127:0] e_rd, e_rk, e_ct;
                int           n;
                e_rn = '0; e_rd = '0; e_rk = '0;
                e_ir = (m_mode[g] == 0);
                e_busy = (m_mode[g] != 0);
                e_ov = (m_mode[g] == 2);
                e_ct = m_last[g];
                if (m_mode[g] == 1) begin
                    n    = (cyc - m_acc[g] - 1) / rl_of(g);
                    e_rn = 4'(n + 1);
                    e_rd = exp_data(m_pt[g], m_k[g], n);
                    e_rk = exp_key(m_k[g], n);
                    e_ct = e_rd;
                end
                chk($sformatf("inst%0d in_ready", g),  128'(in_ready[g]),  128'(e_ir));
                chk($sformatf("inst%0d busy", g),      128'(busy[g]),      128'(e_busy));
                chk($sformatf("inst%0d out_valid", g), 128'(out_valid[g]), 128'(e_ov));
                chk($sformatf("inst%0d rnd_num", g),   128'(rnd_num[g]),   128'(e_rn));
                chk($sformatf("inst%0d rnd_data", g),  rnd_data[g],        e_rd);
                chk($sformatf("inst%0d rnd_key", g),   rnd_key[g],         e_rk);
                chk($sformatf("inst%0d cipher", g),    ct[g],              e_ct);
            end
        end
    end

    // run one block; returns after OUT_VALID seen, at posedge+2 alignment
    task automatic run_block(input int g, input logic [127:0] p, input logic [127:0] k,
                             input int exp_lat, input logic [127:0] exp_ct, input string tag);
        int lat;
        pt[g] = p;
        ck[g] = k;
        in_valid[g] = 1'b1;
        @(posedge clk);
        #2;
        in_valid[g] = 1'b0;
        pt[g] = ~p;
        ck[g] = ~k;
        lat = 0;
        while (!out_valid[g] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        #1;
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, " ciphertext"}, ct[g], exp_ct);
    endtask

    task automatic handshake(input int g);
        out_ready[g] = 1'b1;
        @(posedge clk);
        #2;
        out_ready[g] = 1'b0;
        @(posedge clk);
        #2;
    endtask

    logic [127:0] res_q [$];
    int           acc_t [$];

    initial begin
        cyc = 0;
        n_tests = 0;
        n_fail = 0;
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b0;
            in_valid[g] = 1'b0;
            out_ready[g] = 1'b0;
            pt[g] = '0;
            ck[g] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("reset in_ready", 128'(in_ready[0]), 128'd1);
        chk("reset out_valid", 128'(out_valid[0]), 128'd0);
        chk("reset busy", 128'(busy[0]), 128'd0);
        chk("reset cipher", ct[0], 128'd0);
        for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
        @(posedge clk);
        #2;

        // defaults, zero inputs: sum 1..10
        run_block(0, 128'h0, 128'h0, 10, 128'h37, "dflt");
        handshake(0);

        // ROUND_LAT=3: 0xF0 + 0x37
        run_block(1, 128'hFF, 128'h0F, 30, 128'h127, "lat3");
        handshake(1);

        // OUT_READY held low in DONE with a stray IN_VALID pulse
        run_block(0, 128'h1234, 128'h1, 10, 128'h126C, "hold");
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = (i == 2);
            @(posedge clk);
            #2;
        end
        in_valid[0] = 1'b0;
        chk("hold in_ready", 128'(in_ready[0]), 128'd0);
        chk("hold cipher", ct[0], 128'h126C);
        handshake(0);

        // back-to-back blocks with constant handshakes
        pt[0] = 128'h100;
        ck[0] = 128'h0;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (out_valid[0]) res_q.push_back(ct[0]);
            if (in_ready[0]) acc_t.push_back(cyc);
            @(posedge clk);
            #2;
            if (acc_t.size() >= 1) pt[0] = 128'h200;
        end
        in_valid[0] = 1'b0;
        chk("b2b accept count", 128'(acc_t.size()), 128'd3);
        if (acc_t.size() >= 2) chk("b2b accept spacing", 128'(acc_t[1] - acc_t[0]), 128'd12);
        chk("b2b result count", 128'(res_q.size()), 128'd2);
        if (res_q.size() >= 2) begin
            chk("b2b result0", res_q[0], 128'h137);
            chk("b2b result1", res_q[1], 128'h237);
        end
        repeat (14) @(posedge clk);
        #2;
        out_ready[0] = 1'b0;

        // reset during round 4
        pt[0] = 128'h5;
        ck[0] = 128'h3;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #2;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset rnd_num", 128'(rnd_num[0]), 128'd4);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("async rst in_ready", 128'(in_ready[0]), 128'd1);
        chk("async rst busy", 128'(busy[0]), 128'd0);
        chk("async rst rnd_num", 128'(rnd_num[0]), 128'd0);
        chk("async rst rnd_data", rnd_data[0], 128'd0);
        chk("async rst cipher", ct[0], 128'd0);
        @(posedge clk);
        #2;
        rst_n[0] = 1'b1;
        out_ready[0] = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        out_ready[0] = 1'b0;
        run_block(0, 128'h7, 128'h2, 10, 128'h3C, "post-rst");
        handshake(0);

        // NUM_ROUNDS=1
        run_block(2, 128'h10, 128'h01, 1, 128'h12, "nr1");
        handshake(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
